// File: rtl/pri_dec_pulse.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pri_dec_pulse                                                |
// | Description : Queues {q,v} priority codes and replays each as a one-hot    |
// |               pulse of PULSE_LEN cycles followed by GAP_LEN idle cycles.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pri_dec_pulse #(
  parameter int W         = 2,
  parameter int DEPTH     = 4,
  parameter int PULSE_LEN = 3,
  parameter int GAP_LEN   = 1
) (
  input  logic                       Clock,
  input  logic                       Reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_q,
  input  logic                       in_v,
  input  logic                       flush,
  output logic [(2**W)-1:0]          out_d,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int c_N  = 2**W;
  localparam int c_CW = $clog2(DEPTH+1);
  localparam int c_PW = $clog2(DEPTH);
  localparam logic [c_CW-1:0] c_DEPTH    = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
  localparam logic [c_PW-1:0] c_PTR_ONE  = c_PW'(1);
  localparam logic [c_N-1:0]  c_ONE_HOT0 = c_N'(1);
  localparam logic [7:0]      c_PULSE_LD = 8'(PULSE_LEN - 1);
  localparam logic [7:0]      c_GAP_LD   = 8'(GAP_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_cnt, w_cnt_nxt;
  logic [c_N-1:0]  r_out, w_out_nxt;
  logic [W-1:0]    r_mem [DEPTH];
  logic [c_PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic            w_push, w_pop;

  // No pop-bypass: readiness depends only on the registered occupancy.
  assign in_ready = Reset_n && (r_count < c_DEPTH) && !flush;
  assign w_push   = in_valid && in_ready && in_v;
  assign w_pop    = (r_state == S_IDLE) && (r_count != '0) && !flush;

  assign out_d = r_out;
  assign count = r_count;
  assign busy  = (r_state != S_IDLE) || (r_count != '0);

  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_q;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_out_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            w_state_nxt = S_PULSE;
            w_cnt_nxt   = c_PULSE_LD;
            w_out_nxt   = c_ONE_HOT0 << r_mem[r_rd_ptr];
          end
        end
        S_PULSE: begin
          if (r_cnt != 8'd0) begin
            w_cnt_nxt = r_cnt - 8'd1;
          end else begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = c_GAP_LD;
            w_out_nxt   = '0;
          end
        end
        S_GAP: begin
          if (r_cnt != 8'd0) begin
            w_cnt_nxt = r_cnt - 8'd1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_out_nxt   = '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
